// File: rtl/cap_pkg.sv
// Shared types and default constants for the time-multiplexed trapezoidal capacitor integrator.
package cap_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, SCAN, STROBE} cap_state_e;

  localparam int unsigned DW        = 16;
  localparam int unsigned VW        = 24;
  localparam int unsigned KW        = 18;
  localparam int unsigned KFRAC     = 16;
  localparam int unsigned K_DEFAULT = 1311;

  // Voltage increment for one trapezoidal step at the default widths.
  function automatic logic signed [VW-1:0] trap_dv(logic signed [DW-1:0] i,
                                                   logic signed [DW-1:0] i_prev,
                                                   logic [KW-1:0] k);
    logic signed [DW:0]      sum;
    logic signed [DW+KW+1:0] prod;
    sum  = {i[DW-1], i} + {i_prev[DW-1], i_prev};
    prod = {{(KW + 1){sum[DW]}}, sum} * {{(DW + 2){1'b0}}, k};
    return VW'(prod >>> KFRAC);
  endfunction

endpackage

// File: rtl/cap_trap_step.sv
// Combinational trapezoidal update v + floor((i + i_prev) * K / 2^KFRAC).
// With CAP_SAT_EN defined the result clamps to the VW-bit signed range and flags it.
module cap_trap_step #(
  parameter int unsigned DW    = 16,
  parameter int unsigned VW    = 24,
  parameter int unsigned KW    = 18,
  parameter int unsigned KFRAC = 16,
  parameter int unsigned K     = 1311
) (
  input  logic [DW-1:0] i_cur,
  input  logic [DW-1:0] i_prev,
  input  logic [VW-1:0] v_cur,
`ifdef CAP_SAT_EN
  output logic          sat,
`endif
  output logic [VW-1:0] v_next
);
  import cap_pkg::*;

  localparam int unsigned PRW = DW + KW + 2;
  localparam int unsigned AW  = ((PRW > VW) ? PRW : VW) + 1;

  logic        [DW:0]   sum;
  logic signed [PRW-1:0] prod;
  logic signed [PRW-1:0] dv;
  logic signed [AW-1:0]  v_ext;
  logic signed [AW-1:0]  dv_ext;

  assign sum    = {i_cur[DW-1], i_cur} + {i_prev[DW-1], i_prev};
  // K is unsigned, so it is zero-extended before the signed multiply.
  assign prod   = $signed({{(PRW - DW - 1){sum[DW]}}, sum}) *
                  $signed({{(PRW - KW){1'b0}}, KW'(K)});
  assign dv     = prod >>> KFRAC;
  assign v_ext  = $signed({{(AW - VW){v_cur[VW-1]}}, v_cur});
  assign dv_ext = $signed({{(AW - PRW){dv[PRW-1]}}, dv});

`ifdef CAP_SAT_EN
  logic signed [AW-1:0] acc;
  assign acc    = v_ext + dv_ext;
  // In range only when every bit above the VW-bit sign position matches the sign.
  assign sat    = (acc[AW-1:VW-1] != {(AW - VW + 1){acc[AW-1]}});
  assign v_next = !sat        ? acc[VW-1:0] :
                  acc[AW-1]   ? {1'b1, {(VW - 1){1'b0}}} :
                                {1'b0, {(VW - 1){1'b1}}};
`else
  assign v_next = VW'(v_ext + dv_ext);
`endif

endmodule

// File: rtl/cap_integ_sched.sv
// Sequencer sharing one trapezoidal integrator across N_CH capacitor channels.
// Define CAP_SAT_EN for saturating accumulation and the sticky sat_flag output.
module cap_integ_sched #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned DW    = cap_pkg::DW,
  parameter int unsigned VW    = cap_pkg::VW,
  parameter int unsigned KW    = cap_pkg::KW,
  parameter int unsigned KFRAC = cap_pkg::KFRAC,
  parameter int unsigned K     = cap_pkg::K_DEFAULT,
  parameter int unsigned PW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [PW-1:0]     step_period,
  input  logic [N_CH*DW-1:0] i_probe,
  output logic [N_CH*VW-1:0] vout,
  output logic              vout_valid,
  output logic              busy,
`ifdef CAP_SAT_EN
  output logic              sat_flag,
`endif
  output logic [31:0]       step_count
);
  import cap_pkg::*;

  localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  cap_state_e       state_q;
  logic [PW-1:0]    cnt_q;
  logic [IW-1:0]    idx_q;
  logic [VW-1:0]    v_q    [N_CH];
  logic [DW-1:0]    ip_q   [N_CH];
  logic [DW-1:0]    snap_q [N_CH];
  logic [N_CH-1:0]  en_q;
  logic             stop_q;
  logic             valid_q;
  logic [31:0]      count_q;
  logic [PW-1:0]    period_m1;
  logic [VW-1:0]    v_next;

  assign period_m1 = (step_period == '0) ? '0 : step_period - PW'(1);

`ifdef CAP_SAT_EN
  logic sat_q;
  logic sat_step;
  assign sat_flag = sat_q;
`endif

  cap_trap_step #(
    .DW    (DW),
    .VW    (VW),
    .KW    (KW),
    .KFRAC (KFRAC),
    .K     (K)
  ) u_step (
    .i_cur  (snap_q[idx_q]),
    .i_prev (ip_q[idx_q]),
    .v_cur  (v_q[idx_q]),
`ifdef CAP_SAT_EN
    .sat    (sat_step),
`endif
    .v_next (v_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= '0;
      stop_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        v_q[c]    <= '0;
        ip_q[c]   <= '0;
        snap_q[c] <= '0;
      end
`ifdef CAP_SAT_EN
      sat_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (state_q != IDLE && stop) stop_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (clear) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
              v_q[c]  <= '0;
              ip_q[c] <= '0;
            end
`ifdef CAP_SAT_EN
            sat_q <= 1'b0;
`endif
          end
          if (start && !stop) begin
            cnt_q   <= period_m1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - PW'(1);
          end else begin
            for (int unsigned c = 0; c < N_CH; c++) snap_q[c] <= i_probe[c*DW +: DW];
            en_q    <= ch_en;
            idx_q   <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (en_q[idx_q]) begin
            v_q[idx_q]  <= v_next;
            ip_q[idx_q] <= snap_q[idx_q];
`ifdef CAP_SAT_EN
            if (sat_step) sat_q <= 1'b1;
`endif
          end
          if (idx_q == IW'(N_CH - 1)) begin
            valid_q <= 1'b1;
            count_q <= count_q + 32'd1;
            state_q <= STROBE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        STROBE: begin
          if (stop_q || stop) begin
            stop_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q   <= period_m1;
            state_q <= WAIT;
          end
        end
      endcase
    end
  end

  always_comb begin
    vout = '0;
    for (int unsigned c = 0; c < N_CH; c++) vout[c*VW +: VW] = v_q[c];
  end

  assign busy       = (state_q != IDLE);
  assign vout_valid = valid_q;
  assign step_count = count_q;

endmodule

// File: tb/tb_cap_integ_sched.sv
// Scoreboard bench: two schedulers (K = 1.0 and default K) share stimulus; a reference model
// predicts each strobe's cycle and voltages, and a negedge monitor compares.
module tb_cap_integ_sched;

  localparam int N  = 4;
  localparam longint KA = 65536;
  localparam longint KB = 1311;
  localparam longint VMAX = 8388607;
  localparam longint VMIN = -8388608;

  logic        clk = 1'b0;
  logic        rst, start, stop, clear;
  logic [3:0]  ch_en;
  logic [15:0] step_period;
  logic [63:0] i_probe;
  logic [95:0] vout_a, vout_b;
  logic        vv_a, vv_b, busy_a, busy_b;
  logic [31:0] cnt_a, cnt_b;
`ifdef CAP_SAT_EN
  logic        sat_a, sat_b;
`endif

  always #5 clk = ~clk;

  cap_integ_sched #(
    .N_CH(4), .DW(16), .VW(24), .KW(18), .KFRAC(16), .K(65536), .PW(16)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .ch_en(ch_en),
    .step_period(step_period), .i_probe(i_probe), .vout(vout_a), .vout_valid(vv_a),
    .busy(busy_a),
`ifdef CAP_SAT_EN
    .sat_flag(sat_a),
`endif
    .step_count(cnt_a)
  );

  cap_integ_sched #(
    .N_CH(4), .DW(16), .VW(24), .KW(18), .KFRAC(16), .K(1311), .PW(16)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .ch_en(ch_en),
    .step_period(step_period), .i_probe(i_probe), .vout(vout_b), .vout_valid(vv_b),
    .busy(busy_b),
`ifdef CAP_SAT_EN
    .sat_flag(sat_b),
`endif
    .step_count(cnt_b)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [95:0] got, logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    int unsigned cyc;
    logic [95:0] va;
    logic [95:0] vb;
    logic [31:0] cnt;
    logic        sa;
    logic        sb;
  } exp_t;

  exp_t q[$];

  // Reference model state.
  longint      mv_a[N];
  longint      mv_b[N];
  longint      mip[N];
  logic [31:0] mcount;
  logic        msat_a, msat_b;

  int          plan_i[160][N];
  logic [3:0]  plan_en[160];

  function automatic longint floor_dv(longint s, longint k);
    longint p = s * k;
    longint d = p / 65536;
    if (p < 0 && (p % 65536) != 0) d = d - 1;
    return d;
  endfunction

  function automatic longint fit(longint x);
`ifdef CAP_SAT_EN
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
`else
    longint m = 64'sd16777216;
    longint r = x % m;
    if (r < 0) r = r + m;
    if (r > VMAX) r = r - m;
    return r;
`endif
  endfunction

  task automatic model_clear();
    for (int c = 0; c < N; c++) begin
      mv_a[c] = 0;
      mv_b[c] = 0;
      mip[c]  = 0;
    end
    msat_a = 1'b0;
    msat_b = 1'b0;
  endtask

  task automatic model_step(int k, int unsigned tcyc);
    exp_t   e;
    longint ra, rb;
    for (int c = 0; c < N; c++) begin
      if (plan_en[k][c]) begin
        ra = mv_a[c] + floor_dv(longint'(plan_i[k][c]) + mip[c], KA);
        rb = mv_b[c] + floor_dv(longint'(plan_i[k][c]) + mip[c], KB);
        if (ra > VMAX || ra < VMIN) msat_a = 1'b1;
        if (rb > VMAX || rb < VMIN) msat_b = 1'b1;
        mv_a[c] = fit(ra);
        mv_b[c] = fit(rb);
        mip[c]  = plan_i[k][c];
      end
    end
    mcount = mcount + 32'd1;
    e.cyc = tcyc;
    e.cnt = mcount;
    for (int c = 0; c < N; c++) begin
      e.va[c*24 +: 24] = 24'(mv_a[c]);
      e.vb[c*24 +: 24] = 24'(mv_b[c]);
    end
`ifdef CAP_SAT_EN
    e.sa = msat_a;
    e.sb = msat_b;
`else
    e.sa = 1'b0;
    e.sb = 1'b0;
`endif
    q.push_back(e);
  endtask

  // Monitor: every strobe must match the oldest outstanding prediction.
  exp_t me;
  always @(negedge clk) begin
    if (!rst && (vv_a || vv_b)) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got pulse at cycle %0d, expected none", cyc);
      end else begin
        me = q.pop_front();
        check("valid_both", 96'({vv_a, vv_b}), 96'(2'b11));
        check("strobe_cycle", 96'(cyc), 96'(me.cyc));
        check("vout_a", vout_a, me.va);
        check("vout_b", vout_b, me.vb);
        check("step_count_a", 96'(cnt_a), 96'(me.cnt));
        check("step_count_b", 96'(cnt_b), 96'(me.cnt));
`ifdef CAP_SAT_EN
        check("sat_a", 96'(sat_a), 96'(me.sa));
        check("sat_b", 96'(sat_b), 96'(me.sb));
`endif
      end
    end
  end

  task automatic step_to(int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_step(int k);
    ch_en = plan_en[k];
    for (int c = 0; c < N; c++) i_probe[c*16 +: 16] = 16'(plan_i[k][c]);
  endtask

  // Runs n steps, stopping during the last step's WAIT; noise pulses start+clear while busy.
  task automatic run(int n, int p, logic noise);
    int unsigned pe  = (p == 0) ? 1 : p;
    int unsigned itv = pe + N + 1;
    int unsigned acc = 0;
    step_period = 16'(p);
    for (int k = 0; k < n; k++) begin
      drive_step(k);
      if (k == 0) begin
        start = 1'b1;
        acc   = cyc + 1;
      end
      model_step(k, acc + pe + N + k * itv);
      step_to(acc + k * itv);
      start = 1'b0;
      if (k == n - 1) stop = 1'b1;
      if (noise) begin
        clear = 1'b1;
        start = 1'b1;
      end
      step_to(acc + k * itv + 1);
      stop  = 1'b0;
      clear = 1'b0;
      start = 1'b0;
      step_to(acc + pe + N + k * itv);
    end
    step_to(cyc + 1);
    check("idle_after_stop_a", 96'(busy_a), 96'(0));
    check("idle_after_stop_b", 96'(busy_b), 96'(0));
  endtask

  task automatic clear_idle();
    clear = 1'b1;
    step_to(cyc + 1);
    clear = 1'b0;
    model_clear();
    check("clear_vout_a", vout_a, 96'(0));
    check("clear_vout_b", vout_b, 96'(0));
  endtask

  logic signed [15:0] rnd16;
  int                 rp, rn;
  int unsigned        racc;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    ch_en = '0; step_period = 16'd1; i_probe = '0;
    model_clear();
    mcount = '0;
    step_to(3);
    check("reset_vout_a", vout_a, 96'(0));
    check("reset_vout_b", vout_b, 96'(0));
    check("reset_busy", 96'(busy_a), 96'(0));
    check("reset_valid", 96'(vv_a), 96'(0));
    check("reset_count", 96'(cnt_a), 96'(0));
    rst = 1'b0;
    step_to(cyc + 2);

    // ch0 = 100 on K = 1.0, ch1 = 1000 on default K; period 2.
    for (int k = 0; k < 3; k++) begin
      plan_en[k] = 4'b0011;
      plan_i[k]  = '{100, 1000, 0, 0};
    end
    run(3, 2, 1'b0);
    check("plan_a_ch0_500", 96'(vout_a[23:0]), 96'(500));
    check("plan_b_ch1_100", 96'(vout_b[47:24]), 96'(100));
    check("plan_a_ch3_zero", 96'(vout_a[95:72]), 96'(0));

    // Negative current with floor rounding.
    clear_idle();
    plan_en[0] = 4'b0100; plan_i[0] = '{0, 0, -3, 0};
    plan_en[1] = 4'b0100; plan_i[1] = '{0, 0, 1, 0};
    run(2, 1, 1'b0);
    check("neg_a_ch2_m5", 96'(vout_a[71:48]), 96'(24'hFFFFFB));

    // start and stop together in IDLE: nothing happens.
    start = 1'b1; stop = 1'b1;
    step_to(cyc + 1);
    start = 1'b0; stop = 1'b0;
    step_to(cyc + 5);
    check("start_stop_idle", 96'(busy_a), 96'(0));

    // Accumulator overflow on ch0.
    clear_idle();
    for (int k = 0; k < 130; k++) begin
      plan_en[k] = 4'b0001;
      plan_i[k]  = '{32767, 0, 0, 0};
    end
    run(130, 1, 1'b0);
`ifdef CAP_SAT_EN
    check("ovf_sat_value", 96'(vout_a[23:0]), 96'(24'h7FFFFF));
    check("ovf_sat_flag", 96'(sat_a), 96'(1));
`else
    check("ovf_wrap_sign", 96'(vout_a[23]), 96'(1));
`endif
    clear_idle();

    // Reset while SCAN is on channel 2.
    plan_en[0] = 4'b1111; plan_i[0] = '{500, -700, 900, 1200};
    drive_step(0);
    step_period = 16'd3;
    start = 1'b1;
    racc  = cyc + 1;
    step_to(racc);
    start = 1'b0;
    step_to(racc + 3 + 2);
    rst = 1'b1;
    step_to(cyc + 1);
    check("rst_scan_vout_a", vout_a, 96'(0));
    check("rst_scan_vout_b", vout_b, 96'(0));
    check("rst_scan_count", 96'(cnt_a), 96'(0));
    check("rst_scan_busy", 96'(busy_a), 96'(0));
    rst = 1'b0;
    model_clear();
    mcount = '0;
    run(3, 2, 1'b0);

    // Randomized runs, odd ones with start/clear pulses while busy.
    for (int r = 0; r < 6; r++) begin
      rp = int'($urandom_range(0, 4));
      rn = int'($urandom_range(1, 5));
      for (int k = 0; k < rn; k++) begin
        plan_en[k] = 4'($urandom);
        for (int c = 0; c < N; c++) begin
          if ($urandom_range(0, 1) == 1) begin
            rnd16 = 16'($urandom);
            plan_i[k][c] = int'(rnd16);
          end else begin
            plan_i[k][c] = int'($urandom_range(0, 200)) - 100;
          end
        end
      end
      run(rn, rp, r[0]);
    end

    clear_idle();
    step_to(cyc + 3);
    check("queue_drained", 96'(q.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by time limit, expected finish");
    $fatal(1);
  end

endmodule
